mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  // fetch requester
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic        f_err;
  // data requester
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_ack;
  logic        d_err;
  // shared read return and status
  logic [7:0]  rdata;
  logic        busy;
  // memory side
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_resp;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_resp,
    output f_ack, f_err, d_ack, d_err, rdata, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_resp,
    input  f_ack, f_err, d_ack, d_err, rdata, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter onto a single 8-bit memory port
// with a per-access response timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;

  logic        r_owner;      // 0 = fetch, 1 = data
  logic        r_last;       // requester served at the most recent grant
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  r_wait_cnt;

  logic        w_grant;
  logic        w_grant_data;
  logic        w_wait_done;

  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_f_ack;
  logic        w_d_ack;
  logic        w_f_err;
  logic        w_d_err;

  // Contested requests go to whoever was not served last.
  assign w_grant_data = bus.d_req & (~bus.f_req | ~r_last);
  assign w_grant      = (r_state == S_IDLE) & (bus.f_req | bus.d_req);
  assign w_wait_done  = (r_wait_cnt == LP_WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_f_ack      = 1'b0;
    w_d_ack      = 1'b0;
    w_f_err      = 1'b0;
    w_d_err      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        w_mem_read  = ~r_we;
        w_mem_write = r_we;
        // A response on the last allowed cycle still wins over the timeout.
        if (bus.mem_resp) begin
          w_next_state = S_DONE;
        end else if (w_wait_done) begin
          w_next_state = S_ERR;
        end
      end
      S_DONE: begin
        w_f_ack      = ~r_owner;
        w_d_ack      = r_owner;
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        w_f_err      = ~r_owner;
        w_d_err      = r_owner;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // NOTE: only control and bus-facing registers exist here; all of them get an
  // async reset value because the memory port must be quiet out of reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= 16'h0000;
      r_wdata    <= 8'h00;
      r_rdata    <= 8'h00;
      r_wait_cnt <= 8'h00;
    end else if (w_grant) begin
      r_owner    <= w_grant_data;
      r_last     <= w_grant_data;
      r_we       <= w_grant_data & bus.d_we;
      r_addr     <= w_grant_data ? bus.d_addr  : bus.f_addr;
      r_wdata    <= w_grant_data ? bus.d_wdata : 8'h00;
      r_wait_cnt <= 8'h00;
    end else if (r_state == S_BUSY) begin
      if (bus.mem_resp) begin
        if (!r_we) begin
          r_rdata <= bus.mem_rdata;
        end
      end else if (!w_wait_done) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.f_ack     = w_f_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.f_err     = w_f_err;
  assign bus.d_err     = w_d_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT = 4): a cycle table for arbitration and
// basic transfers, then hand sequences for timeout, late response and reset.
module tb_mem_arbiter;

  logic Clk;
  logic Reset;

  mem_arbiter_if bus_if ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected flag order: busy, mem_read, mem_write, f_ack, f_err, d_ack, d_err
  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        resp;
    logic [7:0]  mrd;
    logic [6:0]  e_flags;
    logic [7:0]  e_rdata;
    logic [15:0] e_maddr;
    logic        chk_wd;
    logic [7:0]  e_wdata;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic logic [6:0] flags();
    return {bus_if.busy, bus_if.mem_read, bus_if.mem_write,
            bus_if.f_ack, bus_if.f_err, bus_if.d_ack, bus_if.d_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [15:0] fa, input logic dr, input logic dwe,
                       input logic [15:0] da, input logic [7:0] dwd, input logic rsp,
                       input logic [7:0] mrd);
    bus_if.f_req     = fr;
    bus_if.f_addr    = fa;
    bus_if.d_req     = dr;
    bus_if.d_we      = dwe;
    bus_if.d_addr    = da;
    bus_if.d_wdata   = dwd;
    bus_if.mem_resp  = rsp;
    bus_if.mem_rdata = mrd;
  endtask

  // Advance to the next cycle, apply inputs, settle away from the rising edge.
  task automatic step(input logic fr, input logic [15:0] fa, input logic dr, input logic dwe,
                      input logic [15:0] da, input logic [7:0] dwd, input logic rsp,
                      input logic [7:0] mrd);
    @(negedge Clk);
    drive(fr, fa, dr, dwe, da, dwd, rsp, mrd);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    // contested out of reset: fetch, data, fetch, data
    vecs[0]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b0000000, 8'h00, 16'h0000, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b1, 8'h11, 7'b1100000, 8'h00, 16'h1111, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b1001000, 8'h11, 16'h1111, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b0000000, 8'h11, 16'h1111, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b1, 8'h22, 7'b1100000, 8'h11, 16'h2222, 1'b1, 8'h5A};
    vecs[5]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b1000010, 8'h22, 16'h2222, 1'b1, 8'h5A};
    vecs[6]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b0000000, 8'h22, 16'h2222, 1'b1, 8'h5A};
    vecs[7]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b1100000, 8'h22, 16'h1111, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b1, 8'h33, 7'b1100000, 8'h22, 16'h1111, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b1001000, 8'h33, 16'h1111, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b0000000, 8'h33, 16'h1111, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 16'h1111, 1'b1, 1'b0, 16'h2222, 8'h5A, 1'b1, 8'h44, 7'b1100000, 8'h33, 16'h2222, 1'b1, 8'h5A};
    vecs[12] = '{1'b0, 16'h1111, 1'b0, 1'b0, 16'h2222, 8'h5A, 1'b0, 8'h00, 7'b1000010, 8'h44, 16'h2222, 1'b1, 8'h5A};
    // single fetch read 0x0100 -> 0x3E
    vecs[13] = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 7'b0000000, 8'h44, 16'h2222, 1'b1, 8'h5A};
    vecs[14] = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h3E, 7'b1100000, 8'h44, 16'h0100, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 16'h0100, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 7'b1001000, 8'h3E, 16'h0100, 1'b0, 8'h00};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 7'b0000000, 8'h3E, 16'h0100, 1'b0, 8'h00};
    // data write 0xFFFE <- 0xA5, rdata must not move
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 8'hA5, 1'b0, 8'h00, 7'b0000000, 8'h3E, 16'h0100, 1'b0, 8'h00};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 8'hA5, 1'b1, 8'h77, 7'b1010000, 8'h3E, 16'hFFFE, 1'b1, 8'hA5};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 8'hA5, 1'b0, 8'h00, 7'b1000010, 8'h3E, 16'hFFFE, 1'b1, 8'hA5};
    // stray mem_resp while idle is ignored
    vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h99, 7'b0000000, 8'h3E, 16'hFFFE, 1'b1, 8'hA5};
    vecs[21] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 7'b0000000, 8'h3E, 16'hFFFE, 1'b1, 8'hA5};

    Reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_we,
           vecs[i].d_addr, vecs[i].d_wdata, vecs[i].resp, vecs[i].mrd);
      check($sformatf("vec%0d flags", i), 32'(flags()), 32'(vecs[i].e_flags));
      check($sformatf("vec%0d rdata", i), 32'(bus_if.rdata), 32'(vecs[i].e_rdata));
      check($sformatf("vec%0d mem_addr", i), 32'(bus_if.mem_addr), 32'(vecs[i].e_maddr));
      if (vecs[i].chk_wd)
        check($sformatf("vec%0d mem_wdata", i), 32'(bus_if.mem_wdata), 32'(vecs[i].e_wdata));
    end

    // Data read never answered: 4 strobe cycles, then d_err only.
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00);
      check($sformatf("timeout busy%0d flags", k), 32'(flags()), 32'(7'b1100000));
    end
    check("timeout mem_addr", 32'(bus_if.mem_addr), 32'h0042);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00);
    check("timeout err flags", 32'(flags()), 32'(7'b1000001));
    check("timeout rdata", 32'(bus_if.rdata), 32'h3E);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    check("timeout idle flags", 32'(flags()), 32'(7'b0000000));

    // Response lands on the last allowed wait cycle: ack wins.
    step(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 8'h00);
      check($sformatf("late busy%0d flags", k), 32'(flags()), 32'(7'b1100000));
    end
    step(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 8'hC3);
    check("late last flags", 32'(flags()), 32'(7'b1100000));
    step(1'b0, 16'h0500, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 8'h00);
    check("late ack flags", 32'(flags()), 32'(7'b1001000));
    check("late rdata", 32'(bus_if.rdata), 32'hC3);

    // Reset in the middle of a data read, both requesters holding.
    step(1'b1, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b0, 8'h00);
    check("pre-reset idle flags", 32'(flags()), 32'(7'b0000000));
    step(1'b1, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b0, 8'h00);
    check("pre-reset busy flags", 32'(flags()), 32'(7'b1100000));
    check("pre-reset mem_addr", 32'(bus_if.mem_addr), 32'h0700);
    #1;
    Reset = 1'b1;
    #1;
    check("async reset flags", 32'(flags()), 32'(7'b0000000));
    check("async reset mem_addr", 32'(bus_if.mem_addr), 32'h0000);
    check("async reset rdata", 32'(bus_if.rdata), 32'h00);
    @(negedge Clk);
    #1;
    check("in reset flags", 32'(flags()), 32'(7'b0000000));
    Reset = 1'b0;
    step(1'b1, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b0, 8'h00);
    check("post-reset fetch flags", 32'(flags()), 32'(7'b1100000));
    check("post-reset fetch mem_addr", 32'(bus_if.mem_addr), 32'h0600);
    step(1'b1, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b1, 8'h5C);
    step(1'b0, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b0, 8'h00);
    check("post-reset fetch ack", 32'(flags()), 32'(7'b1001000));
    check("post-reset fetch rdata", 32'(bus_if.rdata), 32'h5C);
    step(1'b0, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b0, 8'h00);
    step(1'b0, 16'h0600, 1'b1, 1'b0, 16'h0700, 8'h00, 1'b1, 8'hD1);
    check("post-reset data flags", 32'(flags()), 32'(7'b1100000));
    check("post-reset data mem_addr", 32'(bus_if.mem_addr), 32'h0700);
    step(1'b0, 16'h0600, 1'b0, 1'b0, 16'h0700, 8'h00, 1'b0, 8'h00);
    check("post-reset data ack", 32'(flags()), 32'(7'b1000010));
    check("post-reset data rdata", 32'(bus_if.rdata), 32'hD1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
